// File: rtl/ecc_point_if.sv
// Request/result bundle between the scalar-multiplication controller and ecc_point_unit.
// Defining ECC_PU_DBG_EN adds the o_dbg_cycles / o_dbg_state debug outputs.
interface ecc_point_if #(
  parameter int unsigned WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_prime;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_px;
  logic [WIDTH-1:0] i_py;
  logic             i_p_inf;
  logic [WIDTH-1:0] i_qx;
  logic [WIDTH-1:0] i_qy;
  logic             i_q_inf;
  logic [WIDTH-1:0] o_rx;
  logic [WIDTH-1:0] o_ry;
  logic             o_r_inf;
  logic             o_busy;
  logic             o_done;
`ifdef ECC_PU_DBG_EN
  logic [15:0]      o_dbg_cycles;
  logic [3:0]       o_dbg_state;

  modport master (
    output i_start, i_prime, i_a, i_px, i_py, i_p_inf, i_qx, i_qy, i_q_inf,
    input  o_rx, o_ry, o_r_inf, o_busy, o_done, o_dbg_cycles, o_dbg_state
  );
  modport slave (
    input  i_start, i_prime, i_a, i_px, i_py, i_p_inf, i_qx, i_qy, i_q_inf,
    output o_rx, o_ry, o_r_inf, o_busy, o_done, o_dbg_cycles, o_dbg_state
  );
`else
  modport master (
    output i_start, i_prime, i_a, i_px, i_py, i_p_inf, i_qx, i_qy, i_q_inf,
    input  o_rx, o_ry, o_r_inf, o_busy, o_done
  );
  modport slave (
    input  i_start, i_prime, i_a, i_px, i_py, i_p_inf, i_qx, i_qy, i_q_inf,
    output o_rx, o_ry, o_r_inf, o_busy, o_done
  );
`endif
endinterface

// File: rtl/ecc_point_unit.sv
// Sequential EC point add/double over GF(p) with shift-add multiplier and Fermat inverse.
// Optional ECC_PU_DBG_EN adds a saturating latency counter and a state probe.
//
// Timing: the cycle after the accepting edge is cycle 1; o_done is high in cycle 2 for the
// special cases and in cycle 2 + 4*W + 2*W*W + 2*W (constant 0) for the general case. The
// general schedule is CHECK(1) NUM(2W: px*px, *3) DEN(W: py*2) INV(2W*W) LAM/RX/RY(3W),
// and addition runs the same schedule with the unused products discarded.
module ecc_point_unit #(
  parameter int unsigned WIDTH = 8
) (
  input logic         i_clk,
  input logic         i_rst,
  ecc_point_if.slave  bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  typedef enum logic [3:0] {
    StIdle, StCheck, StNum, StDen, StInv, StLam, StRx, StRy, StDone
  } state_t;

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[WIDTH]) d = d + {1'b0, m};
    return d[WIDTH-1:0];
  endfunction

  // One MSB-first shift-add step: acc = 2*acc (+ addend) mod m.
  function automatic logic [WIDTH-1:0] mul_step(input logic [WIDTH-1:0] acc,
                                                input logic [WIDTH-1:0] addend,
                                                input logic b, input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] t;
    t = mod_add(acc, acc, m);
    if (b) t = mod_add(t, addend, m);
    return t;
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_p, r_a, r_px, r_py, r_qx, r_qy;
  logic             r_p_inf, r_q_inf, r_dbl, r_ph;
  logic [WIDTH-1:0] r_ma, r_mb, r_acc, r_num, r_den, r_res, r_lam, r_xr;
  logic [CW-1:0]    r_cnt, r_ebit;
  logic [WIDTH-1:0] r_out_rx, r_out_ry;
  logic             r_out_inf, r_busy, r_done;

  logic [WIDTH-1:0] w_acc_nxt, w_exp, w_inv_nxt, w_rx, w_dx;
  logic [WIDTH-1:0] w_sp_x, w_sp_y;
  logic             w_last, w_special, w_sp_inf, w_to_done;

  assign w_acc_nxt = mul_step(r_acc, r_ma, r_mb[r_cnt], r_p);
  assign w_last    = (r_cnt == '0);
  assign w_exp     = r_p - WIDTH'(2);
  assign w_inv_nxt = w_exp[r_ebit] ? w_acc_nxt : r_res;
  assign w_rx      = mod_sub(mod_sub(w_acc_nxt, r_px, r_p), r_qx, r_p);
  assign w_dx      = mod_sub(r_px, w_rx, r_p);
  assign w_to_done = ((r_state == StCheck) && w_special) || ((r_state == StRy) && w_last);

  always_comb begin
    w_special = 1'b1;
    w_sp_x    = '0;
    w_sp_y    = '0;
    w_sp_inf  = 1'b1;
    if (r_p_inf) begin
      w_sp_x   = r_qx;
      w_sp_y   = r_qy;
      w_sp_inf = r_q_inf;
    end else if (r_q_inf) begin
      w_sp_x   = r_px;
      w_sp_y   = r_py;
      w_sp_inf = 1'b0;
    end else if ((r_px == r_qx) && ((r_py != r_qy) || (r_py == '0))) begin
      w_sp_inf = 1'b1;
    end else begin
      w_special = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_out_rx  <= '0;
      r_out_ry  <= '0;
      r_out_inf <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state inside {StNum, StDen, StInv, StLam, StRx, StRy}) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt - CW'(1);
      end
      unique case (r_state)
        StIdle: begin
          if (bus.i_start) begin
            r_p     <= bus.i_prime;
            r_a     <= bus.i_a;
            r_px    <= bus.i_px;
            r_py    <= bus.i_py;
            r_p_inf <= bus.i_p_inf;
            r_qx    <= bus.i_qx;
            r_qy    <= bus.i_qy;
            r_q_inf <= bus.i_q_inf;
            r_busy  <= 1'b1;
            r_state <= StCheck;
          end
        end
        StCheck: begin
          if (w_special) begin
            r_out_rx  <= w_sp_x;
            r_out_ry  <= w_sp_y;
            r_out_inf <= w_sp_inf;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= StDone;
          end else begin
            r_dbl   <= (r_px == r_qx);
            r_ph    <= 1'b0;
            r_ma    <= r_px;
            r_mb    <= r_px;
            r_acc   <= '0;
            r_cnt   <= LastBit;
            r_state <= StNum;
          end
        end
        StNum: begin
          if (w_last) begin
            r_acc <= '0;
            r_cnt <= LastBit;
            if (!r_ph) begin
              r_ph <= 1'b1;
              r_ma <= w_acc_nxt;
              r_mb <= WIDTH'(3);
            end else begin
              r_num   <= r_dbl ? mod_add(w_acc_nxt, r_a, r_p) : mod_sub(r_qy, r_py, r_p);
              r_ma    <= r_py;
              r_mb    <= WIDTH'(2);
              r_state <= StDen;
            end
          end
        end
        StDen: begin
          if (w_last) begin
            r_den   <= r_dbl ? w_acc_nxt : mod_sub(r_qx, r_px, r_p);
            r_res   <= WIDTH'(1);
            r_ebit  <= LastBit;
            r_ph    <= 1'b0;
            r_ma    <= WIDTH'(1);
            r_mb    <= WIDTH'(1);
            r_acc   <= '0;
            r_cnt   <= LastBit;
            r_state <= StInv;
          end
        end
        StInv: begin
          // Square then always multiply by den; the product is kept only if the exponent bit is set.
          if (w_last) begin
            r_acc <= '0;
            r_cnt <= LastBit;
            if (!r_ph) begin
              r_res <= w_acc_nxt;
              r_ma  <= w_acc_nxt;
              r_mb  <= r_den;
              r_ph  <= 1'b1;
            end else begin
              r_res <= w_inv_nxt;
              r_ph  <= 1'b0;
              if (r_ebit == '0) begin
                r_ma    <= r_num;
                r_mb    <= w_inv_nxt;
                r_state <= StLam;
              end else begin
                r_ebit <= r_ebit - CW'(1);
                r_ma   <= w_inv_nxt;
                r_mb   <= w_inv_nxt;
              end
            end
          end
        end
        StLam: begin
          if (w_last) begin
            r_lam   <= w_acc_nxt;
            r_ma    <= w_acc_nxt;
            r_mb    <= w_acc_nxt;
            r_acc   <= '0;
            r_cnt   <= LastBit;
            r_state <= StRx;
          end
        end
        StRx: begin
          if (w_last) begin
            r_xr    <= w_rx;
            r_ma    <= r_lam;
            r_mb    <= w_dx;
            r_acc   <= '0;
            r_cnt   <= LastBit;
            r_state <= StRy;
          end
        end
        StRy: begin
          if (w_last) begin
            r_out_rx  <= r_xr;
            r_out_ry  <= mod_sub(w_acc_nxt, r_py, r_p);
            r_out_inf <= 1'b0;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= StDone;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.o_rx    = r_out_rx;
  assign bus.o_ry    = r_out_ry;
  assign bus.o_r_inf = r_out_inf;
  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;

`ifdef ECC_PU_DBG_EN
  logic [15:0] r_cyc, r_dbg_cycles;
  logic [15:0] w_cyc_inc;

  assign w_cyc_inc = (r_cyc == 16'hFFFF) ? r_cyc : r_cyc + 16'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cyc        <= '0;
      r_dbg_cycles <= '0;
    end else begin
      if (r_state == StIdle) begin
        if (bus.i_start) r_cyc <= 16'd1;
      end else if (r_state != StDone) begin
        r_cyc <= w_cyc_inc;
      end
      if (w_to_done) r_dbg_cycles <= w_cyc_inc;
    end
  end

  assign bus.o_dbg_cycles = r_dbg_cycles;
  assign bus.o_dbg_state  = r_state;
`else
  logic w_unused;
  assign w_unused = w_to_done;
`endif
endmodule

// File: tb/tb_ecc_point_unit.sv
// Directed, table-driven bench for ecc_point_unit (WIDTH=8) with hand-computed results
// on y^2 = x^3 + a*x + b over GF(11), plus busy-poke, start-in-done and mid-INV reset sequences.
module tb_ecc_point_unit;
  localparam int W     = 8;
  localparam int LatG  = 2 + 6 * W + 2 * W * W;
  localparam int LatS  = 2;
  localparam int Limit = 400;

  typedef struct {
    logic [7:0] p, a, px, py;
    logic       pi;
    logic [7:0] qx, qy;
    logic       qi;
    logic [7:0] rx, ry;
    logic       ri;
    int         lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[12];

  always #5 clk = ~clk;

  ecc_point_if #(.WIDTH(W)) bus ();

  ecc_point_unit #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.i_prime = v.p;
    bus.i_a     = v.a;
    bus.i_px    = v.px;
    bus.i_py    = v.py;
    bus.i_p_inf = v.pi;
    bus.i_qx    = v.qx;
    bus.i_qy    = v.qy;
    bus.i_q_inf = v.qi;
  endtask

  // Inputs after acceptance are changed to junk that would give a different result if read.
  task automatic scramble();
    bus.i_prime = 8'd13;
    bus.i_a     = 8'd5;
    bus.i_px    = 8'd1;
    bus.i_py    = 8'd1;
    bus.i_p_inf = 1'b0;
    bus.i_qx    = 8'd7;
    bus.i_qy    = 8'd9;
    bus.i_q_inf = 1'b0;
  endtask

  task automatic run(input vec_t v, input string nm, input int poke, input bit sid);
    int k, lat, bb;
    @(negedge clk);
    drive(v);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    scramble();
    k = 1; lat = 0; bb = 0;
    while (lat == 0 && k <= Limit) begin
      if (bus.o_done) begin
        lat = k;
      end else begin
        if (!bus.o_busy) bb++;
        bus.i_start = (k == poke);
        @(negedge clk);
        k++;
      end
    end
    bus.i_start = 1'b0;
    check({nm, " latency"}, lat, v.lat);
    check({nm, " rx"}, int'(bus.o_rx), int'(v.rx));
    check({nm, " ry"}, int'(bus.o_ry), int'(v.ry));
    check({nm, " r_inf"}, int'(bus.o_r_inf), int'(v.ri));
    check({nm, " busy_gaps"}, bb, 0);
`ifdef ECC_PU_DBG_EN
    check({nm, " dbg_cycles"}, int'(bus.o_dbg_cycles), v.lat);
`endif
    if (sid) bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    check({nm, " done_single"}, int'(bus.o_done), 0);
    check({nm, " rx_hold"}, int'(bus.o_rx), int'(v.rx));
    if (sid) begin
      check({nm, " start_in_done_busy"}, int'(bus.o_busy), 0);
      repeat (3) @(negedge clk);
      check({nm, " start_in_done_idle"}, int'(bus.o_busy | bus.o_done), 0);
    end
  endtask

  initial begin
    int dn;
    //          p      a      px     py     pi    qx     qy     qi    rx     ry     ri    lat
    tbl[0]  = '{8'd11, 8'd1, 8'd2,  8'd7,  1'b0, 8'd2,  8'd7,  1'b0, 8'd5,  8'd2,  1'b0, LatG};
    tbl[1]  = '{8'd11, 8'd1, 8'd2,  8'd7,  1'b0, 8'd5,  8'd2,  1'b0, 8'd8,  8'd3,  1'b0, LatG};
    tbl[2]  = '{8'd11, 8'd1, 8'd2,  8'd7,  1'b0, 8'd2,  8'd4,  1'b0, 8'd0,  8'd0,  1'b1, LatS};
    tbl[3]  = '{8'd11, 8'd1, 8'd3,  8'd4,  1'b1, 8'd5,  8'd2,  1'b0, 8'd5,  8'd2,  1'b0, LatS};
    tbl[4]  = '{8'd11, 8'd1, 8'd8,  8'd3,  1'b0, 8'd1,  8'd1,  1'b1, 8'd8,  8'd3,  1'b0, LatS};
    tbl[5]  = '{8'd11, 8'd1, 8'd6,  8'd6,  1'b1, 8'd0,  8'd0,  1'b1, 8'd0,  8'd0,  1'b1, LatS};
    tbl[6]  = '{8'd11, 8'd1, 8'd3,  8'd0,  1'b0, 8'd3,  8'd0,  1'b0, 8'd0,  8'd0,  1'b1, LatS};
    tbl[7]  = '{8'd11, 8'd1, 8'd5,  8'd2,  1'b0, 8'd8,  8'd3,  1'b0, 8'd3,  8'd6,  1'b0, LatG};
    tbl[8]  = '{8'd11, 8'd1, 8'd5,  8'd2,  1'b0, 8'd5,  8'd2,  1'b0, 8'd10, 8'd2,  1'b0, LatG};
    tbl[9]  = '{8'd11, 8'd1, 8'd8,  8'd3,  1'b0, 8'd2,  8'd7,  1'b0, 8'd10, 8'd2,  1'b0, LatG};
    tbl[10] = '{8'd11, 8'd3, 8'd2,  8'd7,  1'b0, 8'd2,  8'd7,  1'b0, 8'd10, 8'd8,  1'b0, LatG};
    tbl[11] = '{8'd11, 8'd1, 8'd0,  8'd0,  1'b0, 8'd0,  8'd0,  1'b0, 8'd0,  8'd0,  1'b1, LatS};

    bus.i_start = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    check("reset rx", int'(bus.o_rx), 0);
    check("reset ry", int'(bus.o_ry), 0);
    check("reset r_inf", int'(bus.o_r_inf), 0);
    check("reset busy", int'(bus.o_busy), 0);
    check("reset done", int'(bus.o_done), 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run(tbl[i], $sformatf("vec%0d", i), 0, 1'b0);

    // Start pulse while busy must be ignored.
    run(tbl[0], "busy_poke", 10, 1'b0);
    // Start asserted during the done cycle must be ignored; the next start is accepted.
    run(tbl[1], "start_in_done", 0, 1'b1);
    run(tbl[0], "after_sid", 0, 1'b0);

    // Reset in the middle of the inversion: outputs clear, no done, then a clean rerun.
    @(negedge clk);
    drive(tbl[1]);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (59) @(negedge clk);
    check("midinv busy", int'(bus.o_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midinv rst rx", int'(bus.o_rx), 0);
    check("midinv rst ry", int'(bus.o_ry), 0);
    check("midinv rst r_inf", int'(bus.o_r_inf), 0);
    check("midinv rst busy", int'(bus.o_busy), 0);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 250; c++) begin
      if (bus.o_done || bus.o_busy) dn++;
      @(negedge clk);
    end
    check("midinv no_done", dn, 0);
    run(tbl[0], "post_reset_dbl", 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ecc_point_unit.md
Name: ecc_point_unit

Overview:
- Sequential elliptic-curve point add/double engine over GF(p), for curves y^2 = x^3 + a*x + b (mod p).
- Sits directly downstream of the scalar-multiplication controller (Top_ting datapath). The controller issues one point operation per double-and-add step and consumes R.
- Uses a shift-add modular multiplier and a Fermat inverse (x^(p-2)). Handles the point at infinity and all degenerate cases.

Parameters:
- WIDTH, 8, bit width of p, a, and all coordinates. Every operand must satisfy value < p, and p must be an odd prime >= 3.

Ports:
- i_clk  in  1  clock; everything samples on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  request pulse; accepted only in IDLE
- i_prime  in  WIDTH  modulus p
- i_a  in  WIDTH  curve coefficient a
- i_px, i_py  in  WIDTH  point P coordinates
- i_p_inf  in  1  P is the point at infinity
- i_qx, i_qy  in  WIDTH  point Q coordinates
- i_q_inf  in  1  Q is the point at infinity
- o_rx, o_ry  out  WIDTH  result R = P + Q
- o_r_inf  out  1  R is the point at infinity
- o_busy  out  1  high from the cycle after start acceptance until o_done
- o_done  out  1  one-cycle pulse; R is valid in this cycle

Behaviour:
- Reset (i_rst=1 at an edge): state=IDLE; o_rx=0, o_ry=0, o_r_inf=0, o_busy=0, o_done=0. Reset has priority over all activity, including mid-operation; the operation in progress is discarded and no o_done is produced.
- All inputs are latched on the accepting edge; later input changes have no effect. i_start while busy is ignored (no queueing).
- States: IDLE -> CHECK -> {DONE | NUM -> DEN -> INV -> LAM -> RX -> RY -> DONE} -> IDLE.
- CHECK resolves special cases, in priority order:
  1. p_inf: R=Q.
  2. q_inf: R=P.
  3. px==qx and (py!=qy or py==0): R=inf, with o_rx=o_ry=0.
  4. px==qx and py==qy: doubling.
  5. Otherwise: addition.
- Special cases go CHECK -> DONE. o_done is high exactly 2 cycles after the accepting edge.
- Doubling: num = 3*px^2 + a; den = 2*py.
- Addition: num = qy - py; den = qx - px.
- INV: den^(p-2) by MSB-first square-and-multiply over WIDTH exponent bits.
- LAM: lambda = num * inv.
- RX: rx = lambda^2 - px - qx.
- RY: ry = lambda*(px - rx) - py.
- Every intermediate result is fully reduced into [0, p-1].
- Modular add/sub uses WIDTH+1 bits with a single conditional correction.
- Modular multiply is shift-add, MSB-first: WIDTH cycles, each doing a conditional subtract after the double and after the add.
- General-case latency is fixed for a given WIDTH: 2 + 4*WIDTH + 2*WIDTH*WIDTH + 2*WIDTH + small constant cycles. The implementation documents the exact constant, and it must not depend on operand values.
- DONE: o_done=1 for one cycle. o_rx/o_ry/o_r_inf update at DONE and hold until the next DONE or reset.
- If i_start is asserted in the DONE cycle it is ignored; a new start is accepted the cycle after.
- Out-of-range operands: outputs are unspecified, but o_done must still pulse with normal timing (no hang).

Optional Feature:
- Macro: ECC_PU_DBG_EN.
- Defined: adds output o_dbg_cycles [15:0], the cycle count from the accepting edge to o_done of the last operation (saturating at 16'hFFFF, reset 0). Also adds output o_dbg_state [3:0] carrying the current state encoding.
- Undefined: neither port exists, and there is no counter logic.

Test Plan:
- Doubling, p=11, a=1, P=Q=(2,7) -> R=(5,2), o_r_inf=0, single o_done pulse, o_busy high throughout.
- Addition, p=11, a=1, P=(2,7), Q=(5,2) -> R=(8,3); latency identical to the doubling run.
- Inverse points, P=(2,7), Q=(2,4), p=11 -> o_r_inf=1, o_rx=o_ry=0, o_done exactly 2 cycles after start.
- Identity cases: P=inf, Q=(5,2) -> R=(5,2). Then P=(8,3), Q=inf -> (8,3). Then both inf -> inf. Each completes in 2 cycles.
- Robustness, part 1: pulse i_start again while busy; it must be ignored and the result unchanged.
- Robustness, part 2: assert i_rst mid-INV. Required: outputs go to 0 next cycle, no o_done, and a fresh doubling of (2,7) afterwards yields (5,2).
- Tangent of order 2: p=11, a=1, P=Q=(x,0) with any x<11 -> R=inf after 2 cycles, via the py==0 rule.
